// File: rtl/matrix_stream_loader.sv
// rtl/matrix_stream_loader.sv - stream-to-matrix operand loader for the matrix multiplier
// Header beats latch dims, data beats fill A then B row-major; operands are held in DONE until consumed.
module matrix_stream_loader #(
   parameter int DATA_W  = 8,
   parameter int MAX_DIM = 4,
   parameter int DIM_W   = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [1:0]                        ctrl_i,
   input  logic [DATA_W-1:0]                 data_i,
   output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] mat_a_o,
   output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] mat_b_o,
   output logic [DIM_W-1:0]                  r1_o,
   output logic [DIM_W-1:0]                  c1_o,
   output logic [DIM_W-1:0]                  r2_o,
   output logic [DIM_W-1:0]                  c2_o,
   output logic                              mat_valid_o,
   input  logic                              mat_ready_i,
   output logic                              err_o
);
   localparam int               MAT_W = MAX_DIM * MAX_DIM * DATA_W;
   localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
   localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_DONE, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       hdr_cnt_q, hdr_cnt_d;
   logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
   logic [DIM_W-1:0] r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
   logic [MAT_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;

   logic             accept, is_data, is_hdr, clr, dims_ok;
   logic             last_col, last_row;
   logic [DIM_W-1:0] hdr_val, cur_rows, cur_cols;

   function automatic logic dim_in_range(input logic [DIM_W-1:0] d);
      return (d != '0) && (d <= MAX_D);
   endfunction

   assign in_ready_o = (state_q != S_DONE);
   assign accept     = in_valid_i && in_ready_o;
   assign is_data    = (ctrl_i == 2'd0);
   assign is_hdr     = (ctrl_i == 2'd1);
   assign clr        = in_valid_i && (ctrl_i == 2'd2);
   assign hdr_val    = data_i[DIM_W-1:0];

   // The last header beat is still on the bus, so c2 is checked from data_i.
   assign dims_ok = dim_in_range(r1_q) && dim_in_range(c1_q) && dim_in_range(r2_q) &&
                    dim_in_range(hdr_val) && (c1_q == r2_q);

   assign cur_rows = (state_q == S_LOAD_B) ? r2_q : r1_q;
   assign cur_cols = (state_q == S_LOAD_B) ? c2_q : c1_q;
   assign last_col = (col_q == cur_cols - ONE_D);
   assign last_row = (row_q == cur_rows - ONE_D);

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      r1_d      = r1_q;
      c1_d      = c1_q;
      r2_d      = r2_q;
      c2_d      = c2_q;
      mat_a_d   = mat_a_q;
      mat_b_d   = mat_b_q;

      if (clr) begin
         state_d   = S_IDLE;
         hdr_cnt_d = '0;
         row_d     = '0;
         col_d     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept && is_hdr) begin
                  r1_d      = hdr_val;
                  hdr_cnt_d = 2'd1;
                  state_d   = S_HDR;
               end else if (accept && is_data) begin
                  state_d = S_ERR;
               end
            end
            S_HDR: begin
               if (accept && is_data) begin
                  state_d = S_ERR;
               end else if (accept && is_hdr) begin
                  case (hdr_cnt_q)
                     2'd1: begin
                        c1_d      = hdr_val;
                        hdr_cnt_d = 2'd2;
                     end
                     2'd2: begin
                        r2_d      = hdr_val;
                        hdr_cnt_d = 2'd3;
                     end
                     default: begin
                        c2_d      = hdr_val;
                        hdr_cnt_d = '0;
                        if (dims_ok) begin
                           mat_a_d = '0;
                           mat_b_d = '0;
                           row_d   = '0;
                           col_d   = '0;
                           state_d = S_LOAD_A;
                        end else begin
                           state_d = S_ERR;
                        end
                     end
                  endcase
               end
            end
            S_LOAD_A, S_LOAD_B: begin
               if (accept && is_hdr) begin
                  state_d = S_ERR;
               end else if (accept && is_data) begin
                  for (int r = 0; r < MAX_DIM; r++) begin
                     for (int c = 0; c < MAX_DIM; c++) begin
                        if (row_q == r[DIM_W-1:0] && col_q == c[DIM_W-1:0]) begin
                           if (state_q == S_LOAD_A)
                              mat_a_d[(r*MAX_DIM+c)*DATA_W +: DATA_W] = data_i;
                           else
                              mat_b_d[(r*MAX_DIM+c)*DATA_W +: DATA_W] = data_i;
                        end
                     end
                  end
                  if (last_col) begin
                     col_d = '0;
                     if (last_row) begin
                        row_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_DONE;
                     end else begin
                        row_d = row_q + ONE_D;
                     end
                  end else begin
                     col_d = col_q + ONE_D;
                  end
               end
            end
            S_DONE: begin
               if (mat_ready_i) state_d = S_IDLE;
            end
            default: ;  // ERR drops every beat until clear or reset
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         hdr_cnt_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         r1_q      <= '0;
         c1_q      <= '0;
         r2_q      <= '0;
         c2_q      <= '0;
         mat_a_q   <= '0;
         mat_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         r1_q      <= r1_d;
         c1_q      <= c1_d;
         r2_q      <= r2_d;
         c2_q      <= c2_d;
         mat_a_q   <= mat_a_d;
         mat_b_q   <= mat_b_d;
      end
   end

   assign mat_a_o     = mat_a_q;
   assign mat_b_o     = mat_b_q;
   assign r1_o        = r1_q;
   assign c1_o        = c1_q;
   assign r2_o        = r2_q;
   assign c2_o        = c2_q;
   assign mat_valid_o = (state_q == S_DONE);
   assign err_o       = (state_q == S_ERR);

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised stream-to-matrix loader feeding the matrix multiplier. It accepts a byte-style stream tagged by a 2-bit control code: a dimension header, then row-major element data for operand A and operand B, or a clear command. It validates the dimensions, unpacks both operands into flat zero-padded buffers, and presents them to the multiplier with a valid/ready handshake. This generation adds configurable element width and maximum matrix size, input backpressure, dimension checking and a sticky error flag.

## Interface
- DATA_W, 8, element width in bits
- MAX_DIM, 4, maximum rows/cols of either operand (≥1)
- DIM_W, 4, width of dimension fields; must hold MAX_DIM
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  stream beat present
- in_ready  out  1  loader accepts ctrl 0/1 beats this cycle
- ctrl  in  2  0 = element data, 1 = header, 2 = clear, 3 = reserved
- data  in  DATA_W  beat payload
- mat_a  out  MAX_DIM*MAX_DIM*DATA_W  operand A; element (r,c) at bits [(r*MAX_DIM+c)*DATA_W +: DATA_W]
- mat_b  out  MAX_DIM*MAX_DIM*DATA_W  operand B, same packing
- r1, c1, r2, c2  out  DIM_W each  latched dimensions
- mat_valid  out  1  operands complete and stable
- mat_ready  in  1  multiplier consumes operands
- err  out  1  sticky protocol/dimension error

## Operation
- States: IDLE, HDR, LOAD_A, LOAD_B, DONE, ERR.
- Accepted beat (ctrl 0/1) = in_valid & in_ready at a clock edge.
- Clear (ctrl=2 with in_valid=1) acts in every state, regardless of in_ready: next state IDLE, mat_valid=0, err=0, header/row/col counters=0. Buffers and dims are not cleared. ctrl=3 beats are accepted and ignored.
- in_ready = 1 in IDLE, HDR, LOAD_A, LOAD_B, ERR; 0 in DONE.
- IDLE: header beat stores data[DIM_W-1:0] into r1, moves to HDR with header count 1. Data beat goes to ERR.
- HDR: header beats 2, 3, 4 fill c1, r2, c2 in order. On the 4th beat, check 1 ≤ each dim ≤ MAX_DIM and c1 == r2, using the values including the beat just taken.
  - Pass: zero mat_a and mat_b in full; go to LOAD_A with row=col=0.
  - Fail: go to ERR.
  - A data beat while in HDR goes to ERR.
- LOAD_A: each data beat writes element (row,col) of A. col increments; at col == c1-1, col wraps to 0 and row increments. The beat at (r1-1, c1-1) resets row/col and moves to LOAD_B.
- LOAD_B: same procedure over r2×c2 into B. The final beat moves to DONE.
- A header beat in LOAD_A or LOAD_B goes to ERR.
- DONE: mat_valid=1. mat_a, mat_b and dims are held stable. At an edge with mat_ready=1, go to IDLE and drop mat_valid. Clear overrides.
- ERR: err=1. All ctrl 0/1 beats are accepted and dropped. Only clear or RST exits.
- Unused buffer positions (row ≥ dim or col ≥ dim) read zero after any successful header.

## Timing
- Reset values: state IDLE, in_ready=1 (combinational from state), mat_valid=0, err=0, mat_a=0, mat_b=0, r1=c1=r2=c2=0, counters 0.
- RST has priority over clear; clear has priority over all other ctrl codes.
- Dims register one cycle after their beat. The dimension check uses the 4th beat's value combinationally.
- Elements are visible on mat_a/mat_b the cycle after acceptance.
- mat_valid rises the cycle after the last B beat is accepted.
- Minimum load time from the first header beat to mat_valid is 4 + r1*c1 + r2*c2 cycles at full throughput.
- mat_valid falls the cycle after the edge where mat_ready=1. in_ready returns to 1 in that same cycle. The next header may be accepted on the following edge.
- mat_ready while not in DONE has no effect.
- in_valid=0 stalls counters with no state change. Gaps between beats are allowed anywhere.
- RST mid-load discards everything, with all outputs at reset values the next cycle.

## Test plan
- 2×2·2×2, DATA_W=8, MAX_DIM=4: header 2,2,2,2; A=1,2,3,4; B=5,6,7,8.
  - Expect mat_valid one cycle after the last B beat.
  - Expect mat_a elem(0,0)=1, elem(1,1)=4 at index 5, elem(0,2)=0; mat_b elem(1,0)=7 at index 4.
  - Assert mat_ready, then expect mat_valid=0 and in_ready=1 next cycle.
- Non-square 1×3·3×2: A=9,8,7; B=1..6.
  - Expect mat_a indices 0..2 = 9,8,7; mat_b indices 0,1,4,5,8,9 = 1..6; all others 0.
  - Expect mat_valid after 4+3+6 accepted beats.
- Dimension errors:
  - Header 2,3,2,2 (c1≠r2) → err=1 the cycle after the 4th beat, mat_valid stays 0.
  - Header 5,… with MAX_DIM=4 → err.
  - Header 0,… → err.
  - Clear → err=0, state IDLE.
- Protocol errors:
  - Data beat in IDLE → err.
  - Header beat mid LOAD_A → err.
  - In both cases, further beats are accepted but the buffers are unchanged.
- Backpressure and stall:
  - Hold mat_ready=0 for 10 cycles in DONE → in_ready=0, outputs stable, extra beats not taken.
  - Random in_valid gaps during load → same final buffers as the gap-free run.
- Clear/reset mid-load:
  - Clear after 2 A beats → IDLE; a fresh full load then completes correctly.
  - RST asserted in LOAD_B → all outputs at reset values next cycle.
  - Clear and RST in the same cycle → reset values.
